// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the memory slave.
// Holds HTRANS/HBURST/HSIZE/HRESP codes, the slave state enum and a helper
// that turns an HSIZE code into a contiguous byte-lane mask.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  // (1 << (1 << size)) - 1 : one bit per byte covered by the transfer,
  // anchored at lane 0. Only meaningful for sizes up to DWORD.
  function automatic logic [15:0] size_lanes(input logic [2:0] size);
    return (16'd1 << (16'd1 << size)) - 16'd1;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array: MEM_DEPTH x DATA_WIDTH RAM with per-byte write enables.
// Asynchronous read, synchronous write, no reset (contents survive reset).
// Ports:
//   clk    - write clock
//   we     - write strobe
//   be     - byte enables, bit i covers wdata[8i+7:8i]
//   idx    - word index shared by read and write
//   wdata  - write data
//   rdata  - read data of word idx (combinational)
module ahb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  // One narrow array per byte lane keeps every lane single-driven and
  // maps cleanly onto byte-write RAM primitives.
  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[idx] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[idx];
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: parametrised AHB-Lite memory slave.
// Pipelined address/data phases, WAIT_STATES extra cycles per OKAY data
// phase, HSIZE byte-lane writes and the two-cycle ERROR response.
// Ports:
//   HCLK, HRST          - clock, asynchronous active-high reset
//   HSELx, HADDR, HWRITE, HSIZE, HTRANS, HREADY - address phase inputs
//   HBURST, HPROT, HMASTERLOCK - accepted but unused
//   HWDATA              - write data (data phase)
//   HREADYOUT, HRESP, HRDATA - data phase response
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRST,
  input  logic                  HSELx,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTERLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(NB);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  slave_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OFFS_W-1:0]     off_q, off_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;

  logic                  accept;
  logic                  addr_err;
  logic                  phase_done;
  logic                  mem_we;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Burst type, protection and lock do not change slave behaviour.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTERLOCK, HTRANS[0]};

  assign accept = HSELx & HREADY & HTRANS[1];

  // Out of range, wider than the bus, or not aligned to its own size.
  assign addr_err = ((HADDR >> (OFFS_W + IDX_W)) != '0)
                 || (HSIZE > 3'(OFFS_W))
                 || ((HADDR[OFFS_W-1:0] & OFFS_W'((1 << HSIZE) - 1)) != '0);

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    off_d      = off_q;
    size_d     = size_q;
    write_d    = write_q;
    phase_done = 1'b0;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;

    case (state_q)
      ST_IDLE: phase_done = 1'b1;
      ST_DATA: begin
        HREADYOUT = (cnt_q == 4'd0);
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          phase_done = 1'b1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = HRESP_ERROR;
        phase_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing (or absent) data phase lets the overlapping address
    // phase in; otherwise HREADY is low and nothing is sampled.
    if (phase_done) begin
      state_d = ST_IDLE;
      if (accept) begin
        idx_d   = HADDR[OFFS_W +: IDX_W];
        off_d   = HADDR[OFFS_W-1:0];
        size_d  = HSIZE;
        write_d = HWRITE;
        if (addr_err) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_DATA;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
    end
  end

  // Commit on the edge that closes the write data phase, so a read whose
  // data phase follows immediately already sees the new bytes.
  assign mem_we = (state_q == ST_DATA) && (cnt_q == 4'd0) && write_q;
  assign mem_be = NB'(size_lanes(size_q) << off_q);

  assign HRDATA = ((state_q == ST_DATA) && !write_q) ? mem_rdata : '0;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (idx_q),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three instances (0, 2 and 3 wait states) share
// one bus; a byte-addressed memory model predicts responses per transfer.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRST = 1'b1;
  logic        hsel_bus = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = 4'h3;
  logic [1:0]  HTRANS = '0;
  logic        HMASTERLOCK = 1'b0;
  logic [31:0] HWDATA = '0;
  logic [1:0]  sel_dut = '0;

  logic        hreadyout [3];
  logic        hresp [3];
  logic [31:0] hrdata [3];
  logic        hsel [3];
  logic        hready_mux;

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;

  assign hsel[0] = hsel_bus && (sel_dut == 2'd0);
  assign hsel[1] = hsel_bus && (sel_dut == 2'd1);
  assign hsel[2] = hsel_bus && (sel_dut == 2'd2);
  assign hready_mux = hreadyout[sel_dut];

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRST(HRST), .HSELx(hsel[0]), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTERLOCK(HMASTERLOCK), .HREADY(hready_mux), .HWDATA(HWDATA),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRST(HRST), .HSELx(hsel[1]), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTERLOCK(HMASTERLOCK), .HREADY(hready_mux), .HWDATA(HWDATA),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRST(HRST), .HSELx(hsel[2]), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTERLOCK(HMASTERLOCK), .HREADY(hready_mux), .HWDATA(HWDATA),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t      seq [$];
  logic [7:0] model_mem [3][1024];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // 256 words of 4 bytes; size at most a word; naturally aligned.
  function automatic bit is_err(input xfer_t x);
    return (x.addr / 4 >= 256) || (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
    int base;
    base = int'(addr & ~32'd3);
    return {model_mem[d][base+3], model_mem[d][base+2], model_mem[d][base+1], model_mem[d][base]};
  endfunction

  // Byte address a+b lives on lane (a+b)%4 of the bus.
  task automatic model_write(input int d, input xfer_t x);
    int a;
    for (int b = 0; b < (1 << x.size); b++) begin
      a = int'(x.addr) + b;
      model_mem[d][a] = x.wdata[(a % 4) * 8 +: 8];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic add(input bit sel, input logic [1:0] trans, input logic [2:0] burst,
                     input logic [31:0] addr, input bit wr, input logic [2:0] size,
                     input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.burst = burst; x.addr = addr;
    x.wr = wr; x.size = size; x.wdata = wdata;
    seq.push_back(x);
  endtask

  task automatic drive_idle();
    hsel_bus = 1'b0;
    HTRANS   = HTRANS_IDLE;
    HBURST   = HBURST_SINGLE;
  endtask

  // Plays the queued transfers on DUT d, one bus cycle per iteration:
  // address phase of the next item overlaps the data phase of the last
  // accepted one. Starts and ends at posedge+1.
  task automatic run_seq(input int d, input string name);
    int    ai, dp_cyc, last, guard;
    bit    dp_v, ok, phase_end;
    xfer_t dp;
    logic [31:0] exp_rd;
    ai = 0; dp_v = 0; dp_cyc = 0; last = 0; ok = 1; guard = 0;
    sel_dut = 2'(d);
    while ((ai < seq.size() || dp_v) && guard < 5000) begin
      guard++;
      if (ai < seq.size()) begin
        hsel_bus = seq[ai].sel; HTRANS = seq[ai].trans; HBURST = seq[ai].burst;
        HADDR = seq[ai].addr; HWRITE = seq[ai].wr; HSIZE = seq[ai].size;
      end else begin
        drive_idle();
      end
      HWDATA = (dp_v && dp.wr) ? dp.wdata : $urandom();
      @(negedge HCLK);
      if (dp_v) begin
        ok   = !is_err(dp);
        last = ok ? ws_of(d) : 1;
        check($sformatf("%s ready a=%0h c=%0d", name, dp.addr, dp_cyc),
              32'(hreadyout[d]), 32'(dp_cyc == last));
        check($sformatf("%s resp a=%0h c=%0d", name, dp.addr, dp_cyc),
              32'(hresp[d]), 32'(!ok));
        if (dp_cyc == last) begin
          exp_rd = (ok && !dp.wr) ? model_read(d, dp.addr) : 32'd0;
          check($sformatf("%s rdata a=%0h w=%0d", name, dp.addr, dp.wr), hrdata[d], exp_rd);
        end else if (!ok) begin
          check($sformatf("%s err rdata a=%0h", name, dp.addr), hrdata[d], 32'd0);
        end
        phase_end = (dp_cyc == last);
        if (phase_end && ok && dp.wr) model_write(d, dp);
      end else begin
        check($sformatf("%s idle okay", name),
              {hrdata[d][29:0], hreadyout[d], hresp[d]}, 32'h2);
        phase_end = 1;
      end
      @(posedge HCLK); #1;
      if (phase_end) begin
        if (ai < seq.size()) begin
          dp_v = seq[ai].sel && seq[ai].trans[1];
          dp = seq[ai]; dp_cyc = 0;
          ai++;
        end else begin
          dp_v = 0;
        end
      end else begin
        dp_cyc++;
      end
    end
    if (guard >= 5000) begin
      fails++;
      $display("FAIL %s: sequence timeout, observed %0d cycles required < 5000", name, guard);
    end
    drive_idle();
    seq.delete();
  endtask

  logic [31:0] a, old_word;
  logic [2:0]  sz;
  int          r;

  initial begin
    // Reset values on every instance.
    drive_idle();
    repeat (3) @(posedge HCLK);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset ready d%0d", d), 32'(hreadyout[d]), 32'd1);
      check($sformatf("reset resp d%0d", d), 32'(hresp[d]), 32'd0);
      check($sformatf("reset rdata d%0d", d), hrdata[d], 32'd0);
    end
    HRST = 1'b0;
    @(posedge HCLK); #1;

    // Give every word a known value.
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 256; w++) add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'(w * 4), 1, HSIZE_WORD, $urandom());
      run_seq(d, "init");
    end

    // Write then read back-to-back, then a byte write on lane 2.
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h10, 1, HSIZE_WORD, 32'hDEADBEEF);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h10, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h12, 1, HSIZE_BYTE, 32'h11AA2233);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h10, 0, HSIZE_WORD, 32'h0);
    run_seq(0, "rw0");
    check("byte lane result", model_read(0, 32'h10), 32'hDEAABEEF);

    // Error responses; the following reads show memory untouched.
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h400, 1, HSIZE_WORD, 32'h12345678);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h400, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h01, 1, HSIZE_HALF, 32'hFFFFFFFF);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h00, 0, HSIZE_DWORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h00, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h10, 0, HSIZE_WORD, 32'h0);
    run_seq(0, "err0");

    // INCR4 write with a BUSY beat, then INCR4 read.
    add(1, HTRANS_NONSEQ, HBURST_INCR4, 32'h20, 1, HSIZE_WORD, 32'hA0A0A0A0);
    add(1, HTRANS_SEQ,    HBURST_INCR4, 32'h24, 1, HSIZE_WORD, 32'hA1A1A1A1);
    add(1, HTRANS_BUSY,   HBURST_INCR4, 32'h28, 1, HSIZE_WORD, 32'h0);
    add(1, HTRANS_SEQ,    HBURST_INCR4, 32'h28, 1, HSIZE_WORD, 32'hA2A2A2A2);
    add(1, HTRANS_SEQ,    HBURST_INCR4, 32'h2C, 1, HSIZE_WORD, 32'hA3A3A3A3);
    add(1, HTRANS_NONSEQ, HBURST_INCR4, 32'h20, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_SEQ,    HBURST_INCR4, 32'h24, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_SEQ,    HBURST_INCR4, 32'h28, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_SEQ,    HBURST_INCR4, 32'h2C, 0, HSIZE_WORD, 32'h0);
    run_seq(0, "burst0");

    // Two wait states; deselect while a data phase is in progress.
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h10, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h44, 1, HSIZE_HALF, 32'h5A5A0000);
    add(0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h44, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h44, 0, HSIZE_WORD, 32'h0);
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h401, 0, HSIZE_BYTE, 32'h0);
    run_seq(1, "ws2");

    // Reset in the middle of a three-wait-state write.
    sel_dut  = 2'd2;
    a        = 32'h40;
    old_word = model_read(2, a);
    hsel_bus = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    @(posedge HCLK); #1;
    drive_idle();
    HWDATA = ~old_word;
    @(negedge HCLK);
    check("ws3 wait before reset", 32'(hreadyout[2]), 32'd0);
    @(posedge HCLK); #3;
    HRST = 1'b1;
    #1;
    check("mid reset ready", 32'(hreadyout[2]), 32'd1);
    check("mid reset resp", 32'(hresp[2]), 32'd0);
    check("mid reset rdata", hrdata[2], 32'd0);
    @(posedge HCLK); #1;
    HRST = 1'b0;
    add(1, HTRANS_NONSEQ, HBURST_SINGLE, a, 0, HSIZE_WORD, 32'h0);
    run_seq(2, "after reset");
    check("dropped write", model_read(2, a), old_word);

    // Randomised mix of sizes, idles, deselects and errors on each DUT.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 80; n++) begin
        r  = int'($urandom_range(0, 99));
        sz = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 19) == 0) sz = HSIZE_DWORD;
        a = 32'($urandom_range(0, 255) * 4) + ((32'($urandom_range(0, 3)) >> sz) << sz);
        if ($urandom_range(0, 14) == 0) a = a + 32'd1;
        if ($urandom_range(0, 24) == 0) a = a + 32'h400 * 32'($urandom_range(1, 4));
        add(!(r >= 15 && r < 27), (r < 15) ? HTRANS_IDLE : HTRANS_NONSEQ, 3'($urandom_range(0, 7)),
            a, 1'($urandom_range(0, 1)), sz, $urandom());
      end
      run_seq(d, $sformatf("rand d%0d", d));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
